motor_assist_sequencer: RTL and testbench
=========================================

# motor_assist_sequencer

Sequences the motor setpoint path between the assistance algorithm / throttle source and the current-control stage. Gates assistance behind an arm interval, soft-starts and slew-limits the setpoint, kills the motor on brake or excessive tilt, and holds a fault state until the rider returns to a safe condition. Sits in the motor control top level, driving the `AssistanceRequirement` input of current control in place of the raw algorithm output.

## Interface
- `TICK_DIV`, 50000: `c50m` cycles per sequencer tick (1 kHz at 50 MHz); legal range 2..65535.
- `ARM_TICKS`, 200: ticks that start conditions must hold before ramping.
- `HOLD_TICKS`, 500: ticks the output stays zero after brake release.
- `STEP`, 8: maximum setpoint increase per tick.
- `TILT_LIMIT`, 450: tilt kill threshold, in IMU angle units (0.1 degree), compared against |roll| and |pitch|.

Ports:
- `c50m`, input, 1: system clock; the block's only clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `AssistanceRequirement`, input, 12: assistance request, unsigned.
- `ThrottleTest`, input, 12: twist-throttle request, unsigned.
- `MotorModeSelect`, input, 1: 1 selects assistance; 0 selects throttle (only with the macro).
- `BrakeApplied`, input, 1: active-high brake switch, already synchronised.
- `CadenceCheck`, input, 1: 1 means the rider is pedalling.
- `ResolvedRoll`, input, 12: signed two's complement roll.
- `ResolvedPitch`, input, 12: signed two's complement pitch.
- `MotorSetting`, output, 12: sequenced setpoint to current control.
- `MotorEnable`, output, 1: 1 in RAMP and RUN.
- `SeqState`, output, 3: IDLE=0, ARM=1, RAMP=2, RUN=3, BRAKE_HOLD=4, FAULT=5.
- `FaultLatched`, output, 1: 1 while in FAULT.

## Operation
- **Target selection.** `target` = selected request (see Configuration).
- **Tilt detection.** `tilt` = |roll| > TILT_LIMIT or |pitch| > TILT_LIMIT. The absolute value of -2048 saturates to 2047.
- **Start condition.** `go` = target != 0, CadenceCheck = 1, BrakeApplied = 0, and tilt = 0.
- **Priority per cycle.** tilt, then brake, then normal transitions.
  - tilt in any state other than FAULT: go to FAULT.
  - BrakeApplied in ARM, RAMP or RUN: go to BRAKE_HOLD.
- **IDLE.** Setting = 0. Go to ARM when `go`.
- **ARM.** Setting = 0. Tick counter counts ARM_TICKS. If `go` drops, return to IDLE and clear the counter. When the count expires, go to RAMP.
- **RAMP.** On each tick, setting = min(setting + STEP, target); the add is 13-bit and saturates at 4095. When setting == target, go to RUN. If CadenceCheck = 0 or target = 0, go to IDLE.
- **RUN.**
  - On each tick, increases are limited to STEP.
  - Decreases apply on the next clock, not the next tick.
  - If CadenceCheck = 0 or target = 0, go to IDLE.
- **BRAKE_HOLD.** Setting = 0. The counter reloads while BrakeApplied = 1. After release it counts HOLD_TICKS, then the block goes to IDLE. Re-applying the brake restarts the hold.
- **FAULT.** Setting = 0. Exit to IDLE only when tilt = 0 and target = 0 hold for one full tick.
- **Prescaler.** Free-running 16-bit counter; `tick` pulses for one cycle every TICK_DIV cycles. Entering any state clears the state's tick counter; the prescaler itself is not cleared.

## Timing
- All outputs are registered. Reset values: MotorSetting = 0, MotorEnable = 0, SeqState = 0 (IDLE), FaultLatched = 0; the prescaler and the counter are also 0.
- **Kill latency.** Brake or tilt assertion gives MotorSetting = 0 and MotorEnable = 0 on the first rising edge after the input is seen; no tick is needed.
- **Target decrease in RUN.** Output follows on the next edge.
- **Ramp time.** From 0 to T takes ceil(T/STEP) ticks after ARM completes.
- **Simultaneous brake and tilt.** FAULT wins.
- **Brake in IDLE or FAULT.** No state change.
- **Reset mid-operation.** All outputs go to zero asynchronously, the state goes to IDLE, and the block re-arms from scratch after release.

## Configuration
- `MOTOR_SEQ_THROTTLE_OVERRIDE_EN`
  - **Defined:** target = MotorModeSelect ? AssistanceRequirement : ThrottleTest.
  - **Undefined:** target = AssistanceRequirement; MotorModeSelect and ThrottleTest are ignored.
  - All sequencing, safety and priority rules are identical in both builds.

## Test plan
Bench parameters for all scenarios: TICK_DIV=4, ARM_TICKS=3, HOLD_TICKS=2, STEP=8.
- **Normal start.** Request 40, cadence 1, tilt 0 → ARM for 3 ticks, then RAMP with MotorSetting 8, 16, 24, 32, 40 on successive ticks, then RUN with MotorEnable=1.
- **Brake in RUN.** Brake asserted in RUN at setting 40 → next edge MotorSetting=0, SeqState=4. After release, 2 ticks later SeqState=0. Re-brake during the hold restarts the hold count.
- **Tilt, including the saturation corner.**
  - Roll=-451 in RAMP → next edge SeqState=5, FaultLatched=1.
  - Roll back to 0 with request 40 stays in FAULT.
  - Request 0 for one tick goes to IDLE.
  - Roll=-2048 also faults.
- **Cadence loss during ARM and decrease in RUN.**
  - Cadence drops mid-ARM → IDLE with the counter cleared; re-asserting cadence needs the full 3 ticks again.
  - In RUN, request 40 → 10 gives MotorSetting=10 on the next clock.
- **Macro build.** With the macro defined, MotorModeSelect=0, ThrottleTest=16 and AssistanceRequirement=0 → ramps to 16. Without the macro, the same stimulus stays in IDLE.
- **Reset mid-ramp.** reset_n low mid-RAMP → outputs 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/motor_assist_sequencer_if.sv
// rtl/motor_assist_sequencer_if.sv - request/safety inputs and sequenced setpoint outputs of the motor sequencer
interface motor_assist_sequencer_if;
    logic [11:0] AssistanceRequirement;
    logic [11:0] ThrottleTest;
    logic        MotorModeSelect;
    logic        BrakeApplied;
    logic        CadenceCheck;
    logic [11:0] ResolvedRoll;
    logic [11:0] ResolvedPitch;
    logic [11:0] MotorSetting;
    logic        MotorEnable;
    logic [2:0]  SeqState;
    logic        FaultLatched;

    modport master (
        output AssistanceRequirement, ThrottleTest, MotorModeSelect, BrakeApplied,
        output CadenceCheck, ResolvedRoll, ResolvedPitch,
        input  MotorSetting, MotorEnable, SeqState, FaultLatched
    );

    modport slave (
        input  AssistanceRequirement, ThrottleTest, MotorModeSelect, BrakeApplied,
        input  CadenceCheck, ResolvedRoll, ResolvedPitch,
        output MotorSetting, MotorEnable, SeqState, FaultLatched
    );
endinterface

// File: rtl/motor_assist_sequencer.sv
// rtl/motor_assist_sequencer.sv - arm/soft-start/slew sequencer with brake and tilt kill and fault hold
// Optional feature macro MOTOR_SEQ_THROTTLE_OVERRIDE_EN selects the twist throttle when MotorModeSelect=0.
module motor_assist_sequencer #(
    parameter int TICK_DIV   = 50000,
    parameter int ARM_TICKS  = 200,
    parameter int HOLD_TICKS = 500,
    parameter int STEP       = 8,
    parameter int TILT_LIMIT = 450
) (
    input  logic c50m,
    input  logic reset_n,
    motor_assist_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARM        = 3'd1,
        RAMP       = 3'd2,
        RUN        = 3'd3,
        BRAKE_HOLD = 3'd4,
        FAULT      = 3'd5
    } state_t;

    state_t      state;
    logic [15:0] presc;
    logic [15:0] cnt;
    logic [11:0] setting;
    logic        enable;
    logic        fault;

    logic [11:0] target;
    logic [12:0] ramp_sum;
    logic [11:0] ramp_sat;
    logic [11:0] ramp_next;
    logic        tick;
    logic        tilt;
    logic        go;
    logic        brake;
    logic        cadence;

    // |x| of a 12-bit two's complement angle; -2048 has no positive twin and clamps to 2047
    function automatic logic [11:0] abs12(input logic [11:0] v);
        if (v == 12'h800)
            return 12'h7FF;
        else if (v[11])
            return ~v + 12'd1;
        else
            return v;
    endfunction

`ifdef MOTOR_SEQ_THROTTLE_OVERRIDE_EN
    assign target = bus.MotorModeSelect ? bus.AssistanceRequirement : bus.ThrottleTest;
`else
    logic unused_inputs;
    assign target        = bus.AssistanceRequirement;
    assign unused_inputs = ^{bus.MotorModeSelect, bus.ThrottleTest};
`endif

    assign brake     = bus.BrakeApplied;
    assign cadence   = bus.CadenceCheck;
    assign tick      = (presc == 16'(TICK_DIV - 1));
    assign tilt      = (abs12(bus.ResolvedRoll)  > 12'(TILT_LIMIT)) ||
                       (abs12(bus.ResolvedPitch) > 12'(TILT_LIMIT));
    assign go        = (target != 12'd0) && cadence && !brake && !tilt;
    assign ramp_sum  = {1'b0, setting} + 13'(STEP);
    assign ramp_sat  = ramp_sum[12] ? 12'hFFF : ramp_sum[11:0];
    assign ramp_next = (ramp_sat > target) ? target : ramp_sat;

    always_ff @(posedge c50m or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            presc   <= '0;
            cnt     <= '0;
            setting <= '0;
            enable  <= 1'b0;
            fault   <= 1'b0;
        end else begin
            presc <= tick ? 16'd0 : presc + 16'd1;
            if (tilt && state != FAULT) begin
                state   <= FAULT;
                setting <= '0;
                enable  <= 1'b0;
                fault   <= 1'b1;
                cnt     <= '0;
            end else if (brake && (state == ARM || state == RAMP || state == RUN)) begin
                state   <= BRAKE_HOLD;
                setting <= '0;
                enable  <= 1'b0;
                cnt     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (go) begin
                            state <= ARM;
                            cnt   <= '0;
                        end
                    end
                    ARM: begin
                        if (!go) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (tick) begin
                            if (cnt == 16'(ARM_TICKS - 1)) begin
                                state  <= RAMP;
                                enable <= 1'b1;
                                cnt    <= '0;
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                    end
                    RAMP: begin
                        if (!cadence || target == 12'd0) begin
                            state   <= IDLE;
                            setting <= '0;
                            enable  <= 1'b0;
                            cnt     <= '0;
                        end else if (tick) begin
                            setting <= ramp_next;
                            if (ramp_next == target) begin
                                state <= RUN;
                                cnt   <= '0;
                            end
                        end
                    end
                    RUN: begin
                        // decreases bypass the tick so the rider backing off is felt at once
                        if (!cadence || target == 12'd0) begin
                            state   <= IDLE;
                            setting <= '0;
                            enable  <= 1'b0;
                            cnt     <= '0;
                        end else if (target < setting) begin
                            setting <= target;
                        end else if (tick) begin
                            setting <= ramp_next;
                        end
                    end
                    BRAKE_HOLD: begin
                        if (brake) begin
                            cnt <= '0;
                        end else if (tick) begin
                            if (cnt == 16'(HOLD_TICKS - 1)) begin
                                state <= IDLE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                    end
                    FAULT: begin
                        // cnt is a flag here: safe since the previous tick, so a second tick means a full tick held
                        if (tilt || target != 12'd0) begin
                            cnt <= '0;
                        end else if (tick) begin
                            if (cnt != 16'd0) begin
                                state <= IDLE;
                                fault <= 1'b0;
                                cnt   <= '0;
                            end else begin
                                cnt <= 16'd1;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        setting <= '0;
                        enable  <= 1'b0;
                        fault   <= 1'b0;
                        cnt     <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.MotorSetting = setting;
    assign bus.MotorEnable  = enable;
    assign bus.SeqState     = state;
    assign bus.FaultLatched = fault;
endmodule

// File: tb/tb_motor_assist_sequencer.sv
// tb/tb_motor_assist_sequencer.sv - directed scenarios checked against a cycle model and literal expectations
module tb_motor_assist_sequencer;
    localparam int TICK_DIV   = 4;
    localparam int ARM_TICKS  = 3;
    localparam int HOLD_TICKS = 2;
    localparam int STEP       = 8;
    localparam int TILT_LIMIT = 450;

    logic c50m;
    logic reset_n;
    motor_assist_sequencer_if bus();

    motor_assist_sequencer #(
        .TICK_DIV(TICK_DIV), .ARM_TICKS(ARM_TICKS), .HOLD_TICKS(HOLD_TICKS),
        .STEP(STEP), .TILT_LIMIT(TILT_LIMIT)
    ) dut (
        .c50m(c50m),
        .reset_n(reset_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n;

    // state numbers follow the SeqState encoding; ticks counts ticks spent in the current state
    typedef struct packed {
        int st;
        int setting;
        int ticks;
        int cyc;
        bit clean;
    } model_t;
    model_t m;

    function automatic int abs_sat(input logic [11:0] v);
        int s;
        s = $signed(v);
        if (s < 0) s = -s;
        return (s > 2047) ? 2047 : s;
    endfunction

    function automatic int step_up(input int s, input int t);
        int u;
        u = s + STEP;
        if (u > 4095) u = 4095;
        return (u < t) ? u : t;
    endfunction

    function automatic model_t model_next(input model_t c, input int tgt, input bit cad,
                                          input bit brk, input bit tlt);
        model_t nx;
        bit tk;
        bit go;
        nx     = c;
        nx.cyc = c.cyc + 1;
        tk     = (c.cyc % TICK_DIV) == TICK_DIV - 1;
        go     = (tgt != 0) && cad && !brk && !tlt;
        if (tlt && c.st != 5) begin
            nx.st = 5; nx.setting = 0; nx.ticks = 0; nx.clean = 1'b0;
        end else if (brk && c.st >= 1 && c.st <= 3) begin
            nx.st = 4; nx.setting = 0; nx.ticks = 0;
        end else begin
            case (c.st)
                0: if (go) begin nx.st = 1; nx.ticks = 0; end
                1: begin
                    if (!go) begin
                        nx.st = 0; nx.ticks = 0;
                    end else if (tk) begin
                        nx.ticks = c.ticks + 1;
                        if (nx.ticks == ARM_TICKS) begin nx.st = 2; nx.ticks = 0; end
                    end
                end
                2: begin
                    if (!cad || tgt == 0) begin
                        nx.st = 0; nx.setting = 0;
                    end else if (tk) begin
                        nx.setting = step_up(c.setting, tgt);
                        if (nx.setting == tgt) nx.st = 3;
                    end
                end
                3: begin
                    if (!cad || tgt == 0) begin
                        nx.st = 0; nx.setting = 0;
                    end else if (tgt < c.setting) begin
                        nx.setting = tgt;
                    end else if (tk) begin
                        nx.setting = step_up(c.setting, tgt);
                    end
                end
                4: begin
                    if (brk) begin
                        nx.ticks = 0;
                    end else if (tk) begin
                        nx.ticks = c.ticks + 1;
                        if (nx.ticks == HOLD_TICKS) begin nx.st = 0; nx.ticks = 0; end
                    end
                end
                5: begin
                    if (tlt || tgt != 0) begin
                        nx.clean = 1'b0;
                    end else if (tk) begin
                        if (c.clean) begin nx.st = 0; nx.clean = 1'b0; end
                        else nx.clean = 1'b1;
                    end
                end
                default: nx = '0;
            endcase
        end
        return nx;
    endfunction

    function automatic int model_target(input logic sel, input logic [11:0] assist, input logic [11:0] thr);
`ifdef MOTOR_SEQ_THROTTLE_OVERRIDE_EN
        return sel ? int'(assist) : int'(thr);
`else
        return int'(assist) + 0 * int'({sel, thr});
`endif
    endfunction

    always @(posedge c50m or negedge reset_n) begin
        if (!reset_n)
            m <= '0;
        else
            m <= model_next(m,
                            model_target(bus.MotorModeSelect, bus.AssistanceRequirement, bus.ThrottleTest),
                            bus.CadenceCheck, bus.BrakeApplied,
                            (abs_sat(bus.ResolvedRoll) > TILT_LIMIT) || (abs_sat(bus.ResolvedPitch) > TILT_LIMIT));
    end

    initial begin
        c50m = 1'b0;
        forever #5 c50m = ~c50m;
    end

    initial begin
        forever begin
            @(negedge c50m);
            n_cmp++;
            if (int'(bus.SeqState) != m.st || int'(bus.MotorSetting) != m.setting ||
                bus.MotorEnable !== (m.st == 2 || m.st == 3) || bus.FaultLatched !== (m.st == 5)) begin
                n_bad++;
                $display("FAIL model t=%0t: state %0d req %0d, setting %0d req %0d, enable %0b req %0b, fault %0b req %0b",
                         $time, bus.SeqState, m.st, bus.MotorSetting, m.setting,
                         bus.MotorEnable, (m.st == 2 || m.st == 3), bus.FaultLatched, (m.st == 5));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge c50m);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_state(input int s, input int budget, output int cnt);
        cnt = 0;
        while (int'(bus.SeqState) != s && cnt < budget) begin
            cyc();
            cnt++;
        end
        chk($sformatf("wait_state_%0d", s), int'(bus.SeqState), s);
    endtask

    task automatic wait_setting(input int v, input int budget, output int cnt);
        cnt = 0;
        while (int'(bus.MotorSetting) != v && cnt < budget) begin
            cyc();
            cnt++;
        end
        chk($sformatf("wait_setting_%0d", v), int'(bus.MotorSetting), v);
    endtask

    initial begin
        reset_n                   = 1'b0;
        bus.AssistanceRequirement = 12'd0;
        bus.ThrottleTest          = 12'd0;
        bus.MotorModeSelect       = 1'b1;
        bus.BrakeApplied          = 1'b0;
        bus.CadenceCheck          = 1'b0;
        bus.ResolvedRoll          = 12'd0;
        bus.ResolvedPitch         = 12'd0;
        repeat (3) cyc();
        reset_n = 1'b1;
        chk("reset_state", int'(bus.SeqState), 0);
        chk("reset_setting", int'(bus.MotorSetting), 0);
        chk("reset_enable", int'(bus.MotorEnable), 0);
        chk("reset_fault", int'(bus.FaultLatched), 0);

        // normal start: 3 tick arm, then 8/16/24/32/40 one tick apart
        bus.AssistanceRequirement = 12'd40;
        bus.CadenceCheck          = 1'b1;
        wait_state(1, 4, n);
        wait_state(2, 20, n);
        chk_range("arm_duration", n, 9, 12);
        chk("ramp_enable", int'(bus.MotorEnable), 1);
        for (int k = 0; k < 5; k++) begin
            wait_setting(8 * (k + 1), 8, n);
            chk("ramp_spacing", n, 4);
        end
        chk("run_state", int'(bus.SeqState), 3);
        chk("run_enable", int'(bus.MotorEnable), 1);

        // decrease in RUN applies on the next clock
        bus.AssistanceRequirement = 12'd10;
        cyc();
        chk("decrease_setting", int'(bus.MotorSetting), 10);
        chk("decrease_state", int'(bus.SeqState), 3);
        bus.AssistanceRequirement = 12'd40;
        wait_setting(40, 20, n);

        // brake in RUN, then plain hold release
        bus.BrakeApplied = 1'b1;
        cyc();
        chk("brake_setting", int'(bus.MotorSetting), 0);
        chk("brake_state", int'(bus.SeqState), 4);
        chk("brake_enable", int'(bus.MotorEnable), 0);
        repeat (3) cyc();
        bus.BrakeApplied = 1'b0;
        wait_state(0, 12, n);
        chk_range("hold_time", n, 5, 8);
        wait_state(3, 60, n);

        // re-brake during the hold restarts it
        bus.BrakeApplied = 1'b1;
        cyc();
        repeat (2) cyc();
        bus.BrakeApplied = 1'b0;
        repeat (3) cyc();
        bus.BrakeApplied = 1'b1;
        cyc();
        bus.BrakeApplied = 1'b0;
        repeat (4) cyc();
        chk("rebrake_restart", int'(bus.SeqState), 4);
        wait_state(0, 8, n);
        chk_range("rebrake_remaining", n, 1, 4);

        // tilt in RAMP, fault hold and exit
        wait_state(2, 30, n);
        bus.ResolvedRoll = 12'hE3D;
        cyc();
        chk("tilt_state", int'(bus.SeqState), 5);
        chk("tilt_fault", int'(bus.FaultLatched), 1);
        chk("tilt_setting", int'(bus.MotorSetting), 0);
        chk("tilt_enable", int'(bus.MotorEnable), 0);
        bus.ResolvedRoll = 12'd0;
        repeat (10) cyc();
        chk("fault_holds_with_request", int'(bus.SeqState), 5);
        bus.AssistanceRequirement = 12'd0;
        cyc();
        chk("fault_needs_full_tick", int'(bus.SeqState), 5);
        wait_state(0, 10, n);
        chk_range("fault_exit_time", n, 4, 7);
        chk("fault_cleared", int'(bus.FaultLatched), 0);

        // tilt boundaries and brake in IDLE
        bus.ResolvedRoll = 12'hE3E;
        repeat (6) cyc();
        chk("tilt_at_limit", int'(bus.SeqState), 0);
        bus.BrakeApplied = 1'b1;
        repeat (3) cyc();
        chk("brake_in_idle", int'(bus.SeqState), 0);
        bus.BrakeApplied = 1'b0;
        bus.ResolvedRoll = 12'h800;
        cyc();
        chk("roll_min_faults", int'(bus.SeqState), 5);
        chk("roll_min_fault_flag", int'(bus.FaultLatched), 1);
        bus.ResolvedRoll = 12'd0;
        wait_state(0, 10, n);
        bus.ResolvedPitch = 12'h1C3;
        cyc();
        chk("pitch_tilt", int'(bus.SeqState), 5);
        bus.ResolvedPitch = 12'd0;
        wait_state(0, 10, n);

        // simultaneous brake and tilt: FAULT wins
        bus.AssistanceRequirement = 12'd40;
        wait_state(3, 60, n);
        bus.BrakeApplied  = 1'b1;
        bus.ResolvedPitch = 12'h258;
        cyc();
        chk("brake_and_tilt", int'(bus.SeqState), 5);
        bus.BrakeApplied          = 1'b0;
        bus.ResolvedPitch         = 12'd0;
        bus.AssistanceRequirement = 12'd0;
        wait_state(0, 10, n);

        // cadence loss mid-ARM clears the arm count
        bus.AssistanceRequirement = 12'd40;
        wait_state(1, 4, n);
        repeat (5) cyc();
        bus.CadenceCheck = 1'b0;
        cyc();
        chk("cadence_loss_arm", int'(bus.SeqState), 0);
        bus.CadenceCheck = 1'b1;
        wait_state(1, 4, n);
        wait_state(2, 20, n);
        chk_range("rearm_full", n, 9, 12);

        // full-scale request exercises the saturating add
        bus.AssistanceRequirement = 12'hFFF;
        wait_setting(4095, 2200, n);
        chk("saturate_run", int'(bus.SeqState), 3);
        bus.AssistanceRequirement = 12'd0;
        cyc();
        chk("zero_target_state", int'(bus.SeqState), 0);
        chk("zero_target_setting", int'(bus.MotorSetting), 0);

        // throttle source selection
        bus.MotorModeSelect = 1'b0;
        bus.ThrottleTest    = 12'd16;
`ifdef MOTOR_SEQ_THROTTLE_OVERRIDE_EN
        wait_setting(16, 40, n);
        chk("throttle_run", int'(bus.SeqState), 3);
        bus.ThrottleTest    = 12'd0;
        bus.MotorModeSelect = 1'b1;
        wait_state(0, 4, n);
`else
        repeat (30) cyc();
        chk("throttle_ignored_state", int'(bus.SeqState), 0);
        chk("throttle_ignored_setting", int'(bus.MotorSetting), 0);
        bus.ThrottleTest    = 12'd0;
        bus.MotorModeSelect = 1'b1;
`endif

        // asynchronous reset mid-ramp
        bus.AssistanceRequirement = 12'd40;
        wait_state(2, 30, n);
        wait_setting(8, 8, n);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_setting", int'(bus.MotorSetting), 0);
        chk("async_reset_state", int'(bus.SeqState), 0);
        chk("async_reset_enable", int'(bus.MotorEnable), 0);
        cyc();
        cyc();
        reset_n = 1'b1;
        wait_state(1, 4, n);
        wait_state(2, 20, n);
        chk_range("rearm_after_reset", n, 9, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
